// File: rtl/ppu_mem_arbiter.sv
// PPU/CPU/OAM-DMA arbiter for the shared video memory bus.
// Define ARB_CPU_MODE_LOCKOUT_EN to lock the CPU out of OAM/VRAM by PPU mode.
module ppu_mem_arbiter #(
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_rd,
    input  logic [15:0] ppu_addr,
    output logic [7:0]  ppu_rdata,
    input  logic [1:0]  ppu_mode,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;
    logic       cpu_pend_q;
    logic       ppu_pend_q;
    logic [7:0] ppu_hold_q;

    logic cpu_vram, cpu_oam, trig;
    logic dma_own, locked, cpu_gnt, ppu_gnt;

    assign cpu_vram   = (cpu_addr[15:13] == 3'b100);
    assign cpu_oam    = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    assign trig       = cpu_wr && (cpu_addr == DMA_REG_ADDR);
    assign dma_own    = (state_q == S_READ) || (state_q == S_WRITE);
    assign dma_active = (state_q != S_IDLE);

`ifdef ARB_CPU_MODE_LOCKOUT_EN
    assign locked = (dma_active && (cpu_vram || cpu_oam))
                  || (cpu_oam && ppu_mode[1])
                  || (cpu_vram && (ppu_mode == 2'd3));
`else
    logic unused_mode;
    assign unused_mode = ^ppu_mode;
    assign locked      = dma_active && (cpu_vram || cpu_oam);
`endif

    assign ppu_gnt = ppu_rd && !dma_own;
    assign cpu_gnt = (cpu_rd || cpu_wr) && !dma_own && !ppu_rd
                   && !locked && !trig;

    // Read data is valid only the cycle after a grant; otherwise idle values.
    assign cpu_rdata = cpu_pend_q ? mem_rdata : 8'hFF;
    assign ppu_rdata = ppu_pend_q ? mem_rdata : ppu_hold_q;

    // DMA sequencing; a trigger write always restarts the transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        case (state_q)
            S_START: begin
                state_d = S_READ;
                idx_d   = 8'h00;
            end
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                if (idx_q < LAST_IDX) begin
                    state_d = S_READ;
                    idx_d   = idx_q + 8'h01;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = state_q;
        endcase
        if (trig) begin
            state_d = S_START;
            src_d   = cpu_wdata;
        end
    end

    // Bus owner mux: DMA, then PPU, then CPU; forced quiet in reset.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 8'h00;
        if (!rst_n) begin
            mem_rd = 1'b0;
        end else if (state_q == S_READ) begin
            mem_rd   = 1'b1;
            mem_addr = {src_q, 8'h00} + {8'h00, idx_q};
        end else if (state_q == S_WRITE) begin
            mem_wr    = 1'b1;
            mem_addr  = 16'hFE00 + {8'h00, idx_q};
            mem_wdata = mem_rdata;
        end else if (ppu_rd) begin
            mem_rd   = 1'b1;
            mem_addr = ppu_addr;
        end else if (cpu_gnt) begin
            mem_addr = cpu_addr;
            if (cpu_wr) begin
                mem_wr    = 1'b1;
                mem_wdata = cpu_wdata;
            end else begin
                mem_rd = 1'b1;
            end
        end
    end

    // State, DMA pointers and read-return tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 8'h00;
            src_q      <= 8'h00;
            cpu_pend_q <= 1'b0;
            ppu_pend_q <= 1'b0;
            ppu_hold_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            src_q      <= src_d;
            cpu_pend_q <= cpu_gnt && !cpu_wr;
            ppu_pend_q <= ppu_gnt;
            if (ppu_pend_q) begin
                ppu_hold_q <= mem_rdata;
            end
        end
    end

endmodule
